// File: rtl/operand_fetch_sequencer.sv
// Per-queue operand read sequencer: buffers read requests, hands a command to the
// operand queue, then issues credit-limited VRF word reads. Optional ARA_OPFETCH_PERF_EN adds a stall counter.
module operand_fetch_sequencer #(
    parameter int unsigned QueueDepth = 5,
    parameter int unsigned CmdDepth   = 2,
    parameter int unsigned AddrWidth  = 8,
    parameter int unsigned LenWidth   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]  req_len_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic                 queue_cmd_valid_o,
    output logic [LenWidth-1:0]  queue_cmd_len_o,
    input  logic                 queue_cmd_ready_i,
    output logic                 vrf_req_o,
    output logic [AddrWidth-1:0] vrf_addr_o,
    input  logic                 vrf_gnt_i,
    input  logic                 hazard_i,
    output logic                 operand_issued_o,
    input  logic                 operand_consumed_i,
    output logic                 busy_o
`ifdef ARA_OPFETCH_PERF_EN
    ,
    output logic [31:0]          stall_cycles_o
`endif
);

    localparam int unsigned CredW = $clog2(QueueDepth + 1);
    localparam int unsigned PtrW  = (CmdDepth > 1) ? $clog2(CmdDepth) : 1;
    localparam int unsigned CntW  = $clog2(CmdDepth + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] READ = 2'd2;

    logic [AddrWidth-1:0] r_fifo_addr [CmdDepth];
    logic [LenWidth-1:0]  r_fifo_len  [CmdDepth];
    logic [PtrW-1:0]      r_wptr, r_rptr;
    logic [CntW-1:0]      r_count;
    logic                 r_req_ready;
    logic [1:0]           r_state;
    logic [AddrWidth-1:0] r_addr;
    logic [LenWidth-1:0]  r_remaining;
    logic [CredW-1:0]     r_credits;

    logic                 w_push, w_pop, w_vrf_req, w_grant;
    logic [CntW-1:0]      w_count_nxt;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(CmdDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign w_push      = req_valid_i & r_req_ready;
    assign w_pop       = (r_state == IDLE) && (r_count != '0);
    assign w_count_nxt = r_count + CntW'(w_push) - CntW'(w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= req_addr_i;
            r_fifo_len[r_wptr]  <= req_len_i;
        end
    end

    // Ready is registered from next occupancy so it never depends on this cycle's pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_req_ready <= 1'b1;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            r_count     <= w_count_nxt;
            r_req_ready <= (w_count_nxt != CntW'(CmdDepth));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_pop) begin
                    r_addr      <= r_fifo_addr[r_rptr];
                    r_remaining <= r_fifo_len[r_rptr];
                    r_state     <= CMD;
                end
                CMD: if (queue_cmd_ready_i) begin
                    r_state <= (r_remaining == '0) ? IDLE : READ;
                end
                READ: if (w_grant) begin
                    r_addr      <= r_addr + AddrWidth'(1);
                    r_remaining <= r_remaining - LenWidth'(1);
                    if (r_remaining == LenWidth'(1)) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A consume at full credit is a protocol error and is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credits <= CredW'(QueueDepth);
        end else if (w_grant && !operand_consumed_i) begin
            r_credits <= r_credits - CredW'(1);
        end else if (!w_grant && operand_consumed_i && r_credits != CredW'(QueueDepth)) begin
            r_credits <= r_credits + CredW'(1);
        end
    end

    a_no_consume_at_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(operand_consumed_i && !w_grant && r_credits == CredW'(QueueDepth)));

    // Outputs are masked during reset so no handshake or pulse escapes that cycle.
    assign w_vrf_req         = (r_state == READ) && (r_credits != '0) && !hazard_i && !rst_i;
    assign w_grant           = w_vrf_req & vrf_gnt_i;
    assign vrf_req_o         = w_vrf_req;
    assign vrf_addr_o        = r_addr;
    assign operand_issued_o  = w_grant;
    assign queue_cmd_valid_o = (r_state == CMD) && !rst_i;
    assign queue_cmd_len_o   = r_remaining;
    assign req_ready_o       = r_req_ready;
    assign busy_o            = (r_count != '0) || (r_state != IDLE);

`ifdef ARA_OPFETCH_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cycles <= '0;
        end else if (r_state == READ && !w_grant && r_stall_cycles != '1) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
`endif

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Scoreboarded bench for operand_fetch_sequencer: directed scenarios followed by random traffic.
module tb_operand_fetch_sequencer;

    localparam int QD = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_len = '0;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic        queue_cmd_valid_o;
    logic [15:0] queue_cmd_len_o;
    logic        cmd_ready = 1'b1;
    logic        vrf_req_o;
    logic [7:0]  vrf_addr_o;
    logic        gnt = 1'b1;
    logic        hazard = 1'b0;
    logic        operand_issued_o;
    logic        consume = 1'b0;
    logic        busy_o;
`ifdef ARA_OPFETCH_PERF_EN
    logic [31:0] stall_cycles_o;
`endif

    operand_fetch_sequencer #(.QueueDepth(QD), .CmdDepth(2), .AddrWidth(8), .LenWidth(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_addr_i(req_addr), .req_len_i(req_len), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .queue_cmd_valid_o(queue_cmd_valid_o), .queue_cmd_len_o(queue_cmd_len_o), .queue_cmd_ready_i(cmd_ready),
        .vrf_req_o(vrf_req_o), .vrf_addr_o(vrf_addr_o), .vrf_gnt_i(gnt), .hazard_i(hazard),
        .operand_issued_o(operand_issued_o), .operand_consumed_i(consume), .busy_o(busy_o)
`ifdef ARA_OPFETCH_PERF_EN
        , .stall_cycles_o(stall_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected commands and read addresses, outstanding queue entries, reads left in burst.
    logic [7:0]  exp_addr[$];
    logic [15:0] exp_len[$];
    int          occ = 0;
    int          rd_left = 0;
    int          n_issued = 0;
    int          acc_cyc = 0, hs_cyc = 0, first_rd_cyc = 0, last_rd_cyc = 0, busy_fall_cyc = 0;
    bit          first_pending = 0, prev_hold = 0, prev_busy = 0, m_exp_req;
    logic [15:0] prev_len = '0;
    logic [15:0] m_len;
    longint      exp_stall = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_no_vrf_req", {31'd0, vrf_req_o}, 32'd0);
            chk("rst_no_issue", {31'd0, operand_issued_o}, 32'd0);
            chk("rst_no_cmd", {31'd0, queue_cmd_valid_o}, 32'd0);
            exp_addr.delete();
            exp_len.delete();
            occ = 0; rd_left = 0; prev_hold = 0; prev_busy = 0; exp_stall = 0; first_pending = 0;
        end else begin
            m_exp_req = (rd_left > 0) && (occ < QD) && !hazard;
            chk("vrf_req", {31'd0, vrf_req_o}, {31'd0, m_exp_req});
            chk("issued_is_req_and_gnt", {31'd0, operand_issued_o}, {31'd0, vrf_req_o & gnt});
            if (prev_hold) begin
                chk("cmd_valid_held", {31'd0, queue_cmd_valid_o}, 32'd1);
                chk("cmd_len_stable", {16'd0, queue_cmd_len_o}, {16'd0, prev_len});
            end
            if (rd_left > 0 && !operand_issued_o) exp_stall++;
            if (operand_issued_o) begin
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got addr %0h expected no read", vrf_addr_o);
                end else begin
                    chk("vrf_addr", {24'd0, vrf_addr_o}, {24'd0, exp_addr.pop_front()});
                end
                rd_left--; n_issued++; occ++;
                if (first_pending) begin first_rd_cyc = cyc; first_pending = 0; end
                last_rd_cyc = cyc;
            end
            if (consume) occ--;
            if (queue_cmd_valid_o && cmd_ready) begin
                if (exp_len.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd: got len %0h expected no command", queue_cmd_len_o);
                    m_len = queue_cmd_len_o;
                end else begin
                    m_len = exp_len.pop_front();
                    chk("cmd_len", {16'd0, queue_cmd_len_o}, {16'd0, m_len});
                end
                rd_left = int'(m_len);
                hs_cyc = cyc;
                first_pending = (m_len != 0);
            end
            prev_hold = queue_cmd_valid_o && !cmd_ready;
            prev_len  = queue_cmd_len_o;
            if (req_valid && req_ready_o) begin
                acc_cyc = cyc;
                exp_len.push_back(req_len);
                for (int i = 0; i < int'(req_len); i++) exp_addr.push_back(8'(int'(req_addr) + i));
            end
            if (prev_busy && !busy_o) busy_fall_cyc = cyc;
            prev_busy = busy_o;
        end
    end

    // Operand-queue and arbiter emulation; consumes only when the queue holds data.
    int cons_mode = 0;
    bit cons_one = 0;
    bit rnd_ctl = 0;
    always @(posedge clk) begin
        #1;
        case (cons_mode)
            0:       consume = 1'b0;
            1:       consume = (occ > 0);
            default: consume = (occ > 0) && ($urandom_range(0, 1) == 1);
        endcase
        if (cons_one) begin consume = (occ > 0); cons_one = 0; end
        if (rnd_ctl) begin
            gnt       = ($urandom_range(0, 3) != 0);
            hazard    = ($urandom_range(0, 7) == 0);
            cmd_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [15:0] l);
        bit ok = 0;
        req_addr = a; req_len = l; req_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready_o) begin ok = 1; break; end
        end
        if (!ok) begin checks++; errors++; $display("FAIL send_timeout: got no ready expected ready"); end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit ok = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (!busy_o && exp_addr.size() == 0 && exp_len.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin checks++; errors++; $display("FAIL idle_timeout: got busy expected idle"); end
        step();
    endtask

    task automatic wait_issued(input int target, input int bound);
        bit ok = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (n_issued >= target) begin ok = 1; break; end
        end
        if (!ok) begin checks++; errors++; $display("FAIL issue_timeout: got %0d reads expected %0d", n_issued, target); end
    endtask

    int base;
    logic [7:0] cap;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("reset_cmd_valid", {31'd0, queue_cmd_valid_o}, 32'd0);
        chk("reset_cmd_len", {16'd0, queue_cmd_len_o}, 32'd0);
        chk("reset_vrf_req", {31'd0, vrf_req_o}, 32'd0);
        chk("reset_vrf_addr", {24'd0, vrf_addr_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
`ifdef ARA_OPFETCH_PERF_EN
        chk("reset_stall", stall_cycles_o, 32'd0);
`endif
        step();

        // Basic burst with latency checks
        cons_mode = 1; base = n_issued;
        send(8'h10, 16'd3);
        wait_idle(100);
        chk("basic_cmd_latency", 32'(hs_cyc - acc_cyc), 32'd2);
        chk("basic_first_read", 32'(first_rd_cyc - hs_cyc), 32'd1);
        chk("basic_back_to_back", 32'(last_rd_cyc - first_rd_cyc), 32'd2);
        chk("basic_read_count", 32'(n_issued - base), 32'd3);

        // Zero-length request
        base = n_issued;
        send(8'h33, 16'd0);
        wait_idle(100);
        chk("zero_len_busy_clear", 32'(busy_fall_cyc - hs_cyc), 32'd1);
        chk("zero_len_no_read", 32'(n_issued - base), 32'd0);

        // Address wrap
        base = n_issued;
        send(8'hFE, 16'd4);
        wait_idle(100);
        chk("wrap_read_count", 32'(n_issued - base), 32'd4);
        chk("wrap_final_addr", {24'd0, vrf_addr_o}, 32'h02);

        // Command backpressure
        cmd_ready = 1'b0;
        send(8'h50, 16'd2);
        repeat (3) step();
        @(negedge clk);
        chk("bp_cmd_valid", {31'd0, queue_cmd_valid_o}, 32'd1);
        chk("bp_cmd_len", {16'd0, queue_cmd_len_o}, 32'd2);
        step();
        cmd_ready = 1'b1;
        wait_idle(100);

        // Hazard and withheld grant mid-burst
        base = n_issued;
        send(8'h60, 16'd8);
        wait_issued(base + 2, 100);
        step();
        hazard = 1'b1;
        @(negedge clk);
        chk("hazard_blocks", {31'd0, vrf_req_o}, 32'd0);
        cap = vrf_addr_o;
        repeat (2) step();
        hazard = 1'b0;
        @(negedge clk);
        chk("hazard_resume_req", {31'd0, vrf_req_o}, 32'd1);
        chk("hazard_resume_addr", {24'd0, vrf_addr_o}, {24'd0, cap});
        step();
        gnt = 1'b0;
        @(negedge clk);
        cap = vrf_addr_o;
        step();
        @(negedge clk);
        chk("gnt_hold_addr", {24'd0, vrf_addr_o}, {24'd0, cap});
        step();
        gnt = 1'b1;
        wait_idle(100);

        // Reset in the middle of a burst
        base = n_issued;
        send(8'h20, 16'd6);
        wait_issued(base + 2, 100);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_cmd_valid", {31'd0, queue_cmd_valid_o}, 32'd0);
`ifdef ARA_OPFETCH_PERF_EN
        chk("midrst_stall", stall_cycles_o, 32'd0);
`endif
        step();

        // Credit stall: full credit after reset, no consumes
        cons_mode = 0; base = n_issued;
        send(8'h40, 16'd8);
        wait_issued(base + 5, 100);
        repeat (6) step();
        @(negedge clk);
        chk("credit_stall_reads", 32'(n_issued - base), 32'd5);
        chk("credit_stall_req", {31'd0, vrf_req_o}, 32'd0);
        step();
        cons_one = 1;
        repeat (6) step();
        @(negedge clk);
        chk("credit_one_more", 32'(n_issued - base), 32'd6);
        step();
        cons_mode = 1;
        wait_idle(100);

        // Random traffic
        rnd_ctl = 1; cons_mode = 2;
        for (int r = 0; r < 40; r++) begin
            send(8'($urandom), 16'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 4)) step();
        end
        rnd_ctl = 0;
        gnt = 1'b1; hazard = 1'b0; cmd_ready = 1'b1; cons_mode = 1;
        wait_idle(3000);
`ifdef ARA_OPFETCH_PERF_EN
        chk("stall_count", stall_cycles_o, 32'(exp_stall));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
